dual_port_data_memory: RTL

Parametrised successor to the unified instruction/data memory. It has:
- a combinational instruction-fetch port;
- a handshaked data port supporting single reads, paired reads and byte-masked writes, with registered responses and an error flag;
- a hardware clear sequencer that zeroes the array one word per cycle after reset, replacing the single-cycle bulk clear.

It sits between the CPU core and a unified word-addressed RAM. The lower half of the array is data; the upper half is instructions.

---
 rtl/dual_port_data_memory.sv | 133 +++++++++++++
 1 files changed

// File: rtl/dual_port_data_memory.sv
// Unified word-addressed RAM: combinational instruction fetch, handshaked data port
// (read1/read2/byte-masked write) and a post-reset clear sequencer, one word per cycle.
module dual_port_data_memory #(
    parameter int DATA_W        = 32,
    parameter int DEPTH         = 1024,
    parameter int ADDR_W        = 32,
    parameter int IMEM_WRITABLE = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [ADDR_W-1:0]   instruction_address,
    output logic [DATA_W-1:0]   instruction,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [1:0]          req_op,
    input  logic [ADDR_W-1:0]   address1,
    input  logic [ADDR_W-1:0]   address2,
    input  logic [DATA_W-1:0]   write_data,
    input  logic [DATA_W/8-1:0] byte_en,
    output logic [DATA_W-1:0]   data1,
    output logic [DATA_W-1:0]   data2,
    output logic                resp_valid,
    output logic                resp_err,
    output logic                busy
);
    // state | meaning
    // CLEAR | zeroing ram[clr_ptr] each cycle, data port closed
    // READY | normal operation
    localparam int IDX_W = $clog2(DEPTH);
    localparam int BYTES = DATA_W / 8;
    localparam logic [ADDR_W-1:0] HALF_A  = ADDR_W'(DEPTH / 2);
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    typedef enum logic {CLEAR, READY} state_t;

    state_t            state, state_next;
    logic [IDX_W-1:0]  clr_ptr;
    logic [DATA_W-1:0] ram [DEPTH];

    logic             accept;
    logic             wr_legal;
    logic [IDX_W-1:0] idx1, idx2;

    function automatic logic in_data(input logic [ADDR_W-1:0] a);
        return a < HALF_A;
    endfunction

    function automatic logic in_imem(input logic [ADDR_W-1:0] a);
        return (a >= HALF_A) && (a < DEPTH_A);
    endfunction

    assign idx1     = address1[IDX_W-1:0];
    assign idx2     = address2[IDX_W-1:0];
    assign accept   = req_valid && req_ready;
    assign wr_legal = in_data(address1) || ((IMEM_WRITABLE != 0) && in_imem(address1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else begin
            state <= state_next;
            if (state == CLEAR) clr_ptr <= clr_ptr + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        if (state == CLEAR && clr_ptr == IDX_W'(DEPTH - 1)) state_next = READY;
    end

    always_comb begin
        busy      = (state == CLEAR);
        req_ready = (state == READY) && en;
    end

    // The array has no reset of its own; the clear sequencer owns it while busy.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == CLEAR) begin
                ram[clr_ptr] <= '0;
            end else if (accept && req_op == 2'd2 && wr_legal) begin
                for (int b = 0; b < BYTES; b++) begin
                    if (byte_en[b]) ram[idx1][8*b +: 8] <= write_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data1      <= '0;
            data2      <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= accept;
            if (accept) begin
                resp_err <= 1'b0;
                case (req_op)
                    2'd0: begin
                        if (in_data(address1)) begin
                            data1 <= ram[idx1];
                        end else begin
                            data1    <= '0;
                            resp_err <= 1'b1;
                        end
                    end
                    2'd1: begin
                        if (in_data(address1) && in_data(address2)) begin
                            data1 <= ram[idx1];
                            data2 <= ram[idx2];
                        end else begin
                            data1    <= '0;
                            data2    <= '0;
                            resp_err <= 1'b1;
                        end
                    end
                    2'd2:    resp_err <= !wr_legal;
                    default: resp_err <= 1'b1;
                endcase
            end else if (en) begin
                resp_err <= 1'b0;
            end
        end
    end

    // Fetch is hidden (all-ones) while resetting or clearing.
    assign instruction = (!reset && !busy && in_imem(instruction_address))
                         ? ram[instruction_address[IDX_W-1:0]] : '1;

endmodule
